// File: rtl/lane_collector.sv
// lane_collector
//   Receive side of the parity-steered lane router. Each valid beat recovers
//   one bit from the four routed lanes by undoing the parity-keyed swap,
//   accumulates bits per logical channel into FRAME_BITS-wide frames, and
//   presents completed {channel, frame} pairs through a 2-entry FIFO with a
//   valid/ready handshake.
//
//   Optional feature macro: LANE_CHECK_EN
//     defined   : stray activity on any non-selected lane sets sticky lane_err
//     undefined : no checking logic, lane_err tied to 0
module lane_collector #(
    parameter int FRAME_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            sel,
    input  logic [3:0]            key,
    input  logic                  lane0,
    input  logic                  lane1,
    input  logic                  lane2,
    input  logic                  lane3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [1:0]            out_chan,
    output logic [FRAME_BITS-1:0] out_data,
    output logic                  overflow,
    output logic                  lane_err
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    // ------------------------------------------------------------------
    // Lane recovery
    // ------------------------------------------------------------------
    logic [3:0] lane_vec;
    logic [1:0] phys;
    logic       rx_bit;

    assign lane_vec = {lane3, lane2, lane1, lane0};
    // Odd key parity keeps the direct lane, even parity uses the complement.
    assign phys     = (^key) ? sel : ~sel;
    assign rx_bit   = lane_vec[phys];

    // ------------------------------------------------------------------
    // Per-channel frame assembly
    // ------------------------------------------------------------------
    logic [FRAME_BITS-1:0] sr  [4];
    logic [CW-1:0]         cnt [4];

    logic [CW-1:0]         cnt_inc;
    logic [FRAME_BITS-1:0] sr_new;
    logic                  complete;

    assign cnt_inc  = cnt[sel] + 1'b1;
    assign sr_new   = {sr[sel][FRAME_BITS-2:0], rx_bit};
    assign complete = in_valid && (cnt_inc == CW'(FRAME_BITS));

    // Shift the recovered bit into the addressed channel; a completed frame
    // always restarts its counter, even when the FIFO drops the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 4; c++) begin
                sr[c]  <= '0;
                cnt[c] <= '0;
            end
        end else if (in_valid) begin
            sr[sel] <= sr_new;
            if (complete)
                cnt[sel] <= '0;
            else
                cnt[sel] <= cnt_inc;
        end
    end

    // ------------------------------------------------------------------
    // 2-entry output FIFO
    // ------------------------------------------------------------------
    logic [1:0]            mem_chan [2];
    logic [FRAME_BITS-1:0] mem_data [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic [1:0]            count;

    logic full;
    logic pop;
    logic push_ok;
    logic drop;

    assign full    = (count == 2'd2);
    assign pop     = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = complete & (~full | pop);
    assign drop    = complete & full & ~pop;

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_chan[wr_ptr] <= sel;
            mem_data[wr_ptr] <= sr_new;
        end
    end

    // FIFO pointers, occupancy and the registered overflow pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else begin
            overflow <= drop;
            if (push_ok)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head is read straight from storage; zeroed while the FIFO is empty.
    assign out_valid = (count != 2'd0);
    assign out_chan  = out_valid ? mem_chan[rd_ptr] : 2'd0;
    assign out_data  = out_valid ? mem_data[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // Optional stray-lane check
    // ------------------------------------------------------------------
`ifdef LANE_CHECK_EN
    logic [3:0] phys_mask;
    logic       stray;

    assign phys_mask = 4'b0001 << phys;
    assign stray     = |(lane_vec & ~phys_mask);

    // Sticky flag: any non-selected lane high during a beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lane_err <= 1'b0;
        else if (in_valid && stray)
            lane_err <= 1'b1;
    end
`else
    assign lane_err = 1'b0;
`endif

endmodule

// File: tb/tb_lane_collector.sv
// Directed testbench for lane_collector (FRAME_BITS = 4).
module tb_lane_collector;

    localparam int FB = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [1:0]    sel;
    logic [3:0]    key;
    logic          lane0, lane1, lane2, lane3;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    out_chan;
    logic [FB-1:0] out_data;
    logic          overflow;
    logic          lane_err;

    int checks = 0;
    int errors = 0;

    lane_collector #(.FRAME_BITS(FB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .sel       (sel),
        .key       (key),
        .lane0     (lane0),
        .lane1     (lane1),
        .lane2     (lane2),
        .lane3     (lane3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan),
        .out_data  (out_data),
        .overflow  (overflow),
        .lane_err  (lane_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One beat: drive at negedge, sampled at posedge, observe 1 time unit later.
    task automatic beat(input logic [1:0] s, input logic [3:0] k, input logic [3:0] lanes);
        @(negedge clk);
        in_valid = 1'b1;
        sel      = s;
        key      = k;
        {lane3, lane2, lane1, lane0} = lanes;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        {lane3, lane2, lane1, lane0} = 4'b0000;
    endtask

    task automatic pop_one();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_head(input string tag, input logic [1:0] ch, input logic [FB-1:0] d);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_chan"},  32'(out_chan),  32'(ch));
        chk({tag, "_data"},  32'(out_data),  32'(d));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        sel       = 2'd0;
        key       = 4'd0;
        {lane3, lane2, lane1, lane0} = 4'b0000;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_chan",     32'(out_chan),  32'd0);
        chk("rst_data",     32'(out_data),  32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_lane_err", 32'(lane_err),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Odd key 0001, channel 2, lane2 bits 1,0,1,1
        beat(2'd2, 4'b0001, 4'b0100);
        beat(2'd2, 4'b0001, 4'b0000);
        beat(2'd2, 4'b0001, 4'b0100);
        chk("odd_not_yet", 32'(out_valid), 32'd0);
        beat(2'd2, 4'b0001, 4'b0100);
        check_head("odd", 2'd2, 4'b1011);
        pop_one();
        chk("odd_empty_valid", 32'(out_valid), 32'd0);
        chk("odd_empty_data",  32'(out_data),  32'd0);

        // Even key 0011, channel 2 steered to lane1: bits 1,1,0,0
        beat(2'd2, 4'b0011, 4'b0010);
        beat(2'd2, 4'b0011, 4'b0010);
        beat(2'd2, 4'b0011, 4'b0000);
        beat(2'd2, 4'b0011, 4'b0000);
        check_head("even", 2'd2, 4'b1100);
        pop_one();
        // Same key, only lane2 driven: nothing on the steered lane
        repeat (4) beat(2'd2, 4'b0011, 4'b0100);
        check_head("even_wrong_lane", 2'd2, 4'b0000);
        pop_one();

        // Interleaved ch0/ch3, key 0111 (odd): ch0 = 1,0,0,1  ch3 = 0,1,1,1
        beat(2'd0, 4'b0111, 4'b0001);
        beat(2'd3, 4'b0111, 4'b0000);
        beat(2'd0, 4'b0111, 4'b0000);
        beat(2'd3, 4'b0111, 4'b1000);
        beat(2'd0, 4'b0111, 4'b0000);
        beat(2'd3, 4'b0111, 4'b1000);
        beat(2'd0, 4'b0111, 4'b0001);
        check_head("ilv_first", 2'd0, 4'b1001);
        beat(2'd3, 4'b0111, 4'b1000);
        check_head("ilv_first_held", 2'd0, 4'b1001);
        pop_one();
        check_head("ilv_second", 2'd3, 4'b0111);
        pop_one();
        chk("ilv_empty", 32'(out_valid), 32'd0);

        // Overflow: ch1, key 0001 -> lane1. Frames 1010, 0110, 1111
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0000);
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0000);
        beat(2'd1, 4'b0001, 4'b0000);
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0000);
        chk("ovf_none_yet", 32'(overflow), 32'd0);
        check_head("ovf_held1", 2'd1, 4'b1010);
        repeat (4) beat(2'd1, 4'b0001, 4'b0010);
        chk("ovf_pulse", 32'(overflow), 32'd1);
        idle();
        chk("ovf_pulse_end", 32'(overflow), 32'd0);
        check_head("ovf_drain1", 2'd1, 4'b1010);
        pop_one();
        check_head("ovf_drain2", 2'd1, 4'b0110);
        pop_one();
        chk("ovf_drained", 32'(out_valid), 32'd0);
        // Dropped frame still cleared the counter: next frame aligns on 4 beats
        beat(2'd1, 4'b0001, 4'b0000);
        beat(2'd1, 4'b0001, 4'b0000);
        beat(2'd1, 4'b0001, 4'b0010);
        chk("ovf_cnt_cleared", 32'(out_valid), 32'd0);
        beat(2'd1, 4'b0001, 4'b0010);
        check_head("ovf_after", 2'd1, 4'b0011);
        // Leave this frame in the FIFO so reset must clear it.

        // Reset mid-frame: 2 beats on ch1, reset, then 1,1,1,0
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0010);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid",    32'(out_valid), 32'd0);
        chk("mid_rst_chan",     32'(out_chan),  32'd0);
        chk("mid_rst_data",     32'(out_data),  32'd0);
        chk("mid_rst_overflow", 32'(overflow),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        beat(2'd1, 4'b0001, 4'b0010);
        beat(2'd1, 4'b0001, 4'b0010);
        chk("mid_rst_no_stale", 32'(out_valid), 32'd0);
        beat(2'd1, 4'b0001, 4'b0010);
        chk("mid_rst_not_yet", 32'(out_valid), 32'd0);
        beat(2'd1, 4'b0001, 4'b0000);
        check_head("mid_rst", 2'd1, 4'b1110);
        pop_one();

        // Stray lane: sel 0, odd key, lane0 and lane3 high; then 0,0,0
        chk("lc_before", 32'(lane_err), 32'd0);
        beat(2'd0, 4'b0001, 4'b1001);
`ifdef LANE_CHECK_EN
        chk("lc_set", 32'(lane_err), 32'd1);
`else
        chk("lc_tied", 32'(lane_err), 32'd0);
`endif
        beat(2'd0, 4'b0001, 4'b0000);
        beat(2'd0, 4'b0001, 4'b0000);
        beat(2'd0, 4'b0001, 4'b0000);
        check_head("lc_bit", 2'd0, 4'b1000);
        idle();
`ifdef LANE_CHECK_EN
        chk("lc_sticky", 32'(lane_err), 32'd1);
`else
        chk("lc_still_tied", 32'(lane_err), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("lc_rst_clear", 32'(lane_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_collector.md
# lane_collector

Receive-side counterpart of the parity-steered lane router. Each valid beat, the block recovers one bit from the four routed lane lines by undoing the parity-keyed lane swap. It accumulates the bits per logical channel into frames and presents completed frames through a 2-entry output FIFO with a valid/ready handshake. It sits at the far end of the four lane wires and feeds downstream consumers one `{channel, frame}` pair at a time.

## Interface
- `FRAME_BITS`, default 4: bits per frame (2..16).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: beat strobe; lanes, `sel` and `key` are sampled when high.
- `sel` in 2: logical channel of this beat (0..3).
- `key` in 4: parity key nibble used by the sender for lane steering.
- `lane0`..`lane3` in 1 each: routed lane lines.
- `out_valid` out 1: FIFO head holds a frame.
- `out_ready` in 1: consumer accepts the head when `out_valid & out_ready`.
- `out_chan` out 2: channel of the head frame.
- `out_data` out FRAME_BITS: head frame; the first-received bit is in the MSB.
- `overflow` out 1: one-cycle pulse when a completed frame is dropped.
- `lane_err` out 1: sticky stray-lane flag (present only with `LANE_CHECK_EN`; otherwise tied 0).

## Operation
- Physical lane: `phys = (^key) ? sel : ~sel`. Odd parity uses the direct lane; even parity uses the complemented index.
- Recovered bit: `bit = lane[phys]`.
- Per channel c (0..3), the block keeps a FRAME_BITS shift register and a beat counter of width `$clog2(FRAME_BITS+1)`.
- On `in_valid`: shift `bit` into channel `sel` LSB-ward (`sr = {sr[FRAME_BITS-2:0], bit}`) and increment `cnt[sel]`. Other channels are untouched.
- When the incoming beat makes `cnt[sel] == FRAME_BITS`, the frame is complete:
  - push `{sel, new sr}` into the FIFO;
  - clear `cnt[sel]` to 0 in the same cycle, whether or not the push succeeds.
- FIFO: 2 entries, in order across channels.
- The push is dropped when the FIFO is full and no pop happens that cycle. The drop asserts `overflow` for exactly one cycle.
- Full with a simultaneous pop: the push is accepted.
- At most one completion per cycle, because there is only one beat per cycle.
- `out_chan`/`out_data` hold steady while `out_valid & ~out_ready`.
- `out_chan`/`out_data` are don't-care while `out_valid = 0`; they are driven as 0.
- Reset values: `out_valid` 0, `out_chan` 0, `out_data` 0, `overflow` 0, `lane_err` 0. All shift registers, counters and FIFO pointers are cleared.
- Reset mid-frame discards partial bits; the first beat after reset starts a new frame.

## Timing
- Beat to frame visible: the frame completing on beat at edge N shows `out_valid = 1` after edge N when the FIFO was empty. Latency is 1 cycle from the sampling edge.
- Back-to-back completions are accepted every cycle while the FIFO has room or is being popped.
- Pop to next head: combinational from FIFO storage. The new head is visible the cycle after the pop edge.
- `overflow` is registered and asserts in the cycle after the dropping edge.
- No combinational path from `out_ready` to `out_valid`, or from inputs to outputs.

## Configuration
- `LANE_CHECK_EN` defined:
  - On each `in_valid`, any lane other than `phys` that reads 1 sets `lane_err`.
  - `lane_err` is sticky until `rst`.
  - The beat is still used normally.
- `LANE_CHECK_EN` undefined: no checking logic is built and `lane_err` is constant 0.

## Test plan
- **Odd key, channel 2:** beats with `key=4'b0001`, `sel=2`, bits on lane2 = 1,0,1,1.
  - Expected: `out_valid` 1 cycle after 4th beat, `out_chan=2`, `out_data=4'b1011`.
- **Even key, swapped lane:** `key=4'b0011`, `sel=2`, bit driven on lane1 (`~2=1`) = 1,1,0,0.
  - Expected: `out_data=4'b1100`, `out_chan=2`.
  - Also required: driving only lane2 instead yields `4'b0000`.
- **Interleaved channels:** alternate `sel=0` and `sel=3` beats, 8 total, `key=4'b0111`.
  - Expected: two frames pop in completion order, channel 0 first, with independent contents.
- **Overflow:** `out_ready=0`, complete 3 frames.
  - Expected: first two are held; third drops; `overflow` pulses exactly once; `cnt` of that channel is 0.
  - Then `out_ready=1`: the two held frames drain intact.
- **Reset mid-frame:** 2 beats on channel 1, assert `rst`, then 4 beats `1,1,1,0`.
  - Expected: single frame `4'b1110`, all outputs 0 during reset.
- **`LANE_CHECK_EN`:** `sel=0`, odd key, drive lane0=1 and lane3=1.
  - Expected: `lane_err=1` next cycle and stays 1 until `rst`; the bit recovered is 1.
